// File: rtl/weight_loader_if.sv
// Word-stream handshake between the weight source and the weight loader.
//   in_valid : source has a word on in_data
//   in_ready : loader accepts a word this cycle
//   in_data  : signed weight word
//   in_sof   : word is w0 of a new frame
// Modports: master = weight source, slave = weight_loader.
interface weight_loader_if #(
    parameter int unsigned WIDTH = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_sof;

    modport master (
        output in_valid,
        output in_data,
        output in_sof,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sof,
        output in_ready
    );
endinterface

// File: rtl/weight_loader.sv
// Serial weight loader: assembles a framed stream of 9 signed words in a
// shadow bank and copies the full set atomically into the active bank w0..w8
// when commit_en opens a safe window.
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_if         : word-stream handshake (slave side)
//   commit_en     : permission to update the active bank this cycle
//   w0..w8        : active weights (node A: w0-w2, B: w3-w5, C: w6-w8)
//   weights_valid : a full set has been committed since reset
//   commit_done   : one-cycle pulse at the commit edge
//   frame_err     : one-cycle pulse on a framing violation
//   busy          : frame in progress or awaiting commit (combinational)
module weight_loader #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    weight_loader_if.slave          in_if,
    input  logic                    commit_en,
    output logic signed [WIDTH-1:0] w0,
    output logic signed [WIDTH-1:0] w1,
    output logic signed [WIDTH-1:0] w2,
    output logic signed [WIDTH-1:0] w3,
    output logic signed [WIDTH-1:0] w4,
    output logic signed [WIDTH-1:0] w5,
    output logic signed [WIDTH-1:0] w6,
    output logic signed [WIDTH-1:0] w7,
    output logic signed [WIDTH-1:0] w8,
    output logic                    weights_valid,
    output logic                    commit_done,
    output logic                    frame_err,
    output logic                    busy
);
    localparam int unsigned NWORDS = 9;
    localparam int unsigned IDX_W  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]       state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             frame_err_n;
    logic             commit_n;
    logic             xfer;

    logic signed [WIDTH-1:0] shadow [NWORDS];
    logic signed [WIDTH-1:0] active [NWORDS];

    // Handshake decodes straight from state
    assign in_if.in_ready = (state != ST_WAIT);
    assign busy           = (state != ST_IDLE);
    assign xfer           = in_if.in_valid && in_if.in_ready;

    // State and index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next-state, shadow write control and event pulses
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        wr_en       = 1'b0;
        wr_idx      = idx;
        frame_err_n = 1'b0;
        commit_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    if (in_if.in_sof) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        idx_n   = IDX_W'(1);
                        state_n = ST_LOAD;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (in_if.in_sof) begin
                        // Early restart: the new word becomes w0 again
                        frame_err_n = 1'b1;
                        wr_idx      = '0;
                        idx_n       = IDX_W'(1);
                    end else if (idx == IDX_W'(NWORDS - 1)) begin
                        idx_n   = '0;
                        state_n = ST_WAIT;
                    end else begin
                        idx_n = IDX_W'(idx + IDX_W'(1));
                    end
                end
            end
            ST_WAIT: begin
                if (commit_en) begin
                    commit_n = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // Shadow bank, active bank and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NWORDS); i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            weights_valid <= 1'b0;
            commit_done   <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NWORDS); i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    shadow[i] <= in_if.in_data;
                end
                if (commit_n) begin
                    active[i] <= shadow[i];
                end
            end
            if (commit_n) begin
                weights_valid <= 1'b1;
            end
            commit_done <= commit_n;
            frame_err   <= frame_err_n;
        end
    end

    assign w0 = active[0];
    assign w1 = active[1];
    assign w2 = active[2];
    assign w3 = active[3];
    assign w4 = active[4];
    assign w5 = active[5];
    assign w6 = active[6];
    assign w7 = active[7];
    assign w8 = active[8];
endmodule

// File: doc/weight_loader.md
# weight_loader

- Serial weight-programming stage that sits directly upstream of the three-node simple network.
- Accepts a framed stream of 9 signed weight words over a valid/ready handshake and assembles them in a shadow bank.
- Transfers the complete set atomically to the held outputs `w0`..`w8` that drive the network's weight inputs.
- The network never sees a partially loaded weight set.

## Interface
- `WIDTH`, 4, bit width of each signed weight word; must match the network weight width.
- `clk`  in  1  rising-edge clock, shared with the network.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  loader can accept a word this cycle.
- `in_data`  in  WIDTH  signed weight word.
- `in_sof`  in  1  marks the first word (`w0`) of a frame; sampled only on transfer.
- `commit_en`  in  1  permission to update active weights this cycle (network idle window).
- `w0`..`w8`  out  WIDTH each  active signed weights (`w0`/`w1`/`w2`: node A; `w3`/`w4`/`w5`: node B; `w6`/`w7`/`w8`: node C).
- `weights_valid`  out  1  at least one full set committed since reset.
- `commit_done`  out  1  one-cycle pulse, active bank updated at this edge.
- `frame_err`  out  1  one-cycle pulse, framing violation.
- `busy`  out  1  a frame is in progress or awaiting commit.

## Operation
- Transfer occurs on a rising edge where `in_valid && in_ready`.
- Shadow bank: 9 x WIDTH registers. Index counter: 4 bits, range 0..8.
- Active bank: the `w0`..`w8` output registers.
- State IDLE:
  - `in_ready`=1.
  - Transfer with `in_sof`=1: word -> shadow[0], idx=1, go to LOAD.
  - Transfer with `in_sof`=0: word dropped, `frame_err` pulses, stay in IDLE.
- State LOAD:
  - `in_ready`=1.
  - Transfer with `in_sof`=0: word -> shadow[idx], idx+1.
  - If the stored word was idx 8: go to WAIT_COMMIT, idx=0.
  - Transfer with `in_sof`=1 (early restart): `frame_err` pulses, word -> shadow[0], idx=1, stay in LOAD. Earlier partial words are discarded.
- State WAIT_COMMIT:
  - `in_ready`=0.
  - While `commit_en`=1: copy shadow to active bank, set `weights_valid`=1, pulse `commit_done`, go to IDLE.
  - While `commit_en`=0: hold indefinitely.
- `busy`=1 in LOAD and WAIT_COMMIT, 0 in IDLE.
- Weights are passed through unmodified. No arithmetic, saturation or sign change. Two's complement range for WIDTH=4 is -8..+7.
- Active bank changes only on a commit edge. Between commits, `w0`..`w8` are stable regardless of input activity.
- `commit_en` has no effect in IDLE or LOAD.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - State=IDLE, idx=0.
  - `w0`..`w8`=0, `weights_valid`=0, `commit_done`=0, `frame_err`=0.
  - Shadow bank cleared to 0.
  - `in_ready`=1 from the first cycle after deassertion.
- Reset mid-frame or in WAIT_COMMIT: shadow contents are lost, the active bank returns to 0 and `weights_valid` clears.
- Output decode:
  - `in_ready` and `busy` decode combinationally from state.
  - All other outputs are registered.
- Commit latency:
  - The 9th word is accepted at edge N, so state is WAIT_COMMIT from N.
  - With `commit_en`=1 in the cycle after N, the active bank, `weights_valid` and `commit_done` update at edge N+1.
  - Minimum 1 cycle from last word to new weights.
- Throughput: one word per cycle in IDLE/LOAD. Minimum frame-to-frame time is 10 cycles (9 loads + 1 commit).
- `in_ready` drops in the cycle after the 9th transfer. Upstream may hold `in_valid` high. No word is consumed until the commit completes and state is IDLE.
- `frame_err` and `commit_done` are high for exactly one cycle per event, at the edge that accepts or commits.
- The downstream network samples weights on the same `clk`. Commit must be issued only when `commit_en` reflects a safe window; the loader does not check this.

## Test plan
- Reset, then 9 back-to-back words (`sof` on the first) with values 1,-2,3,-4,5,-6,7,-8,0, and `commit_en`=1:
  - `w0`..`w8` equal those values at edge 10.
  - `commit_done` pulses once.
  - `weights_valid`=1.
- Full frame with `commit_en`=0 for 20 cycles, then 1:
  - `in_ready`=0 and `w*` unchanged throughout the wait.
  - Commit occurs on the first edge with `commit_en`=1.
- 4 words, then a word with `sof`=1, then 8 more words:
  - `frame_err` pulses once at the restart.
  - Committed weights are the last 9 words only.
- In IDLE, word with `sof`=0 value 5:
  - `frame_err` pulses.
  - State stays IDLE and shadow[0] is unchanged.
  - The next frame commits correctly.
- Commit set A, then load set B while `commit_en`=0:
  - Outputs stay at A during the whole load.
  - Outputs switch atomically to B at the commit edge.
- Assert `rst_n`=0 asynchronously after the 6th word of a frame:
  - All `w*` are 0 immediately, without a clock edge.
  - `weights_valid`=0.
  - After release, a fresh frame loads normally.
